// File: rtl/ensemble_majority_voter_pkg.sv
// Shared types and the 3-way vote function for the ensemble majority voter.
package ensemble_pkg;
  localparam int LABEL_W = 4;

  localparam logic [1:0] AGREE_ALL  = 2'd3;
  localparam logic [1:0] AGREE_TWO  = 2'd2;
  localparam logic [1:0] AGREE_NONE = 2'd1;

  typedef logic [LABEL_W-1:0] label_t;

  typedef struct packed {
    label_t label;
    logic   last;
  } slot_t;

  typedef struct packed {
    label_t     label;
    logic [1:0] agree;
  } vote_t;

  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_st_e;

  function automatic vote_t majority3(label_t l0, label_t l1, label_t l2, logic [1:0] tie_sel);
    vote_t v;
    if (l0 == l1 || l0 == l2) begin
      v.label = l0;
      v.agree = (l0 == l1 && l0 == l2) ? AGREE_ALL : AGREE_TWO;
    end else if (l1 == l2) begin
      v.label = l1;
      v.agree = AGREE_TWO;
    end else begin
      case (tie_sel)
        2'd0:    v.label = l0;
        2'd1:    v.label = l1;
        default: v.label = l2;
      endcase
      v.agree = AGREE_NONE;
    end
    return v;
  endfunction
endpackage

// File: rtl/ensemble_majority_voter_if.sv
// AXI-Stream bundle used for the three classifier inputs and the vote output.
interface ensemble_majority_voter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/ensemble_majority_voter_in_slot.sv
// One-entry holding slot for a classifier beat; frees on fire, refillable the same edge.
module ensemble_in_slot
  import ensemble_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  valid_i,
  input  slot_t data_i,
  input  logic  fire_i,
  output logic  ready_o,
  output logic  full_o,
  output slot_t data_o
);
  slot_st_e st_q, st_d;
  slot_t    data_q, data_d;
  logic     accept;

  always_comb begin
    ready_o = (st_q == SLOT_EMPTY) || fire_i;
    accept  = valid_i && ready_o;
    st_d    = st_q;
    data_d  = data_q;
    if (accept) begin
      st_d   = SLOT_FULL;
      data_d = data_i;
    end else if (fire_i) begin
      st_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= SLOT_EMPTY;
      data_q <= '0;
    end else begin
      st_q   <= st_d;
      data_q <= data_d;
    end
  end

  assign full_o = (st_q == SLOT_FULL);
  assign data_o = data_q;
endmodule

// File: rtl/ensemble_majority_voter.sv
// Aligns one beat from each of three classifier streams and emits a majority vote.
// Optional ENSEMBLE_VOTE_STATS_EN adds saturating fire/split counters.
module ensemble_majority_voter #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = 4,
  parameter int LABEL_W    = ensemble_pkg::LABEL_W,
  parameter int TIE_SEL    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  ensemble_majority_voter_if.slave   s0_axis,
  ensemble_majority_voter_if.slave   s1_axis,
  ensemble_majority_voter_if.slave   s2_axis,
  ensemble_majority_voter_if.master  m_axis,
  output logic                       tlast_mismatch,
  output logic [31:0]                stat_total,
  output logic [31:0]                stat_split
);
  import ensemble_pkg::*;

  logic [2:0] in_vld, in_rdy, in_full, lasts;
  slot_t      in_data [3];
  slot_t      held    [3];
  logic       fire;
  vote_t      vote;

  assign in_vld     = {s2_axis.tvalid, s1_axis.tvalid, s0_axis.tvalid};
  assign in_data[0] = '{label: s0_axis.tdata[LABEL_W-1:0], last: s0_axis.tlast};
  assign in_data[1] = '{label: s1_axis.tdata[LABEL_W-1:0], last: s1_axis.tlast};
  assign in_data[2] = '{label: s2_axis.tdata[LABEL_W-1:0], last: s2_axis.tlast};
  assign s0_axis.tready = in_rdy[0];
  assign s1_axis.tready = in_rdy[1];
  assign s2_axis.tready = in_rdy[2];

  // tkeep and the upper tdata bits carry nothing the vote uses
  wire unused_ok = ^{s0_axis.tkeep, s1_axis.tkeep, s2_axis.tkeep,
                     s0_axis.tdata[DATA_WIDTH-1:LABEL_W], s1_axis.tdata[DATA_WIDTH-1:LABEL_W],
                     s2_axis.tdata[DATA_WIDTH-1:LABEL_W]};

  for (genvar g = 0; g < 3; g++) begin : g_slot
    ensemble_in_slot u_slot (
      .clk     (clk),
      .rst     (rst),
      .valid_i (in_vld[g]),
      .data_i  (in_data[g]),
      .fire_i  (fire),
      .ready_o (in_rdy[g]),
      .full_o  (in_full[g]),
      .data_o  (held[g])
    );
    assign lasts[g] = held[g].last;
  end

  logic                  m_vld_q, m_vld_d, m_last_q, m_last_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;

  assign fire = (&in_full) && (!m_vld_q || m_axis.tready);
  assign vote = majority3(held[0].label, held[1].label, held[2].label, 2'(TIE_SEL));
  assign tlast_mismatch = fire && (lasts != 3'b000) && (lasts != 3'b111);

  always_comb begin
    m_vld_d  = m_vld_q;
    m_data_d = m_data_q;
    m_last_d = m_last_q;
    if (fire) begin
      m_vld_d                     = 1'b1;
      m_data_d                    = '0;
      m_data_d[LABEL_W-1:0]       = vote.label;
      m_data_d[LABEL_W+1:LABEL_W] = vote.agree;
      m_last_d                    = &lasts;
    end else if (m_axis.tready) begin
      m_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_vld_q  <= 1'b0;
      m_data_q <= '0;
      m_last_q <= 1'b0;
    end else begin
      m_vld_q  <= m_vld_d;
      m_data_q <= m_data_d;
      m_last_q <= m_last_d;
    end
  end

  assign m_axis.tvalid = m_vld_q;
  assign m_axis.tdata  = m_data_q;
  assign m_axis.tlast  = m_last_q;
  assign m_axis.tkeep  = {KEEP_WIDTH{m_vld_q}};

`ifdef ENSEMBLE_VOTE_STATS_EN
  logic [31:0] tot_q, tot_d, split_q, split_d;

  always_comb begin
    tot_d   = tot_q;
    split_d = split_q;
    if (fire && tot_q != 32'hFFFF_FFFF) tot_d = tot_q + 32'd1;
    if (fire && vote.agree == AGREE_NONE && split_q != 32'hFFFF_FFFF) split_d = split_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tot_q   <= '0;
      split_q <= '0;
    end else begin
      tot_q   <= tot_d;
      split_q <= split_d;
    end
  end

  assign stat_total = tot_q;
  assign stat_split = split_q;
`else
  assign stat_total = '0;
  assign stat_split = '0;
`endif
endmodule

// File: tb/tb_ensemble_majority_voter.sv
// Directed bench for ensemble_majority_voter (TIE_SEL=2).
module tb_ensemble_majority_voter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ensemble_majority_voter_if s0 ();
  ensemble_majority_voter_if s1 ();
  ensemble_majority_voter_if s2 ();
  ensemble_majority_voter_if m  ();

  logic        mism;
  logic [31:0] stot, ssplit;
  logic        sv [3];
  logic [3:0]  sl [3];
  logic        st [3];
  logic        rdy[3];
  logic        mrdy;

  assign s0.tdata = 32'(sl[0]); assign s0.tvalid = sv[0]; assign s0.tlast = st[0]; assign s0.tkeep = 4'hF;
  assign s1.tdata = 32'(sl[1]); assign s1.tvalid = sv[1]; assign s1.tlast = st[1]; assign s1.tkeep = 4'hF;
  assign s2.tdata = 32'(sl[2]); assign s2.tvalid = sv[2]; assign s2.tlast = st[2]; assign s2.tkeep = 4'hF;
  assign rdy[0] = s0.tready; assign rdy[1] = s1.tready; assign rdy[2] = s2.tready;
  assign m.tready = mrdy;

  ensemble_majority_voter #(.TIE_SEL(2)) dut (
    .clk(clk), .rst(rst),
    .s0_axis(s0), .s1_axis(s1), .s2_axis(s2), .m_axis(m),
    .tlast_mismatch(mism), .stat_total(stot), .stat_split(ssplit)
  );

  int checks = 0;
  int failures = 0;
  int mcnt = 0;
  logic [32:0] q[$];

  always @(negedge clk) begin
    if (!rst && m.tvalid && m.tready) q.push_back({m.tlast, m.tdata});
    if (mism) mcnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] eb(input int lab, input int agr, input bit last);
    return {last, 32'((agr << 4) | lab)};
  endfunction

  task automatic pop_chk(input string tag, input logic [32:0] exp);
    chk({tag, "_avail"}, 64'(q.size() > 0), 64'd1);
    if (q.size() > 0) chk(tag, 64'(q.pop_front()), 64'(exp));
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive(input logic [2:0] v, input int l0, input int l1, input int l2, input logic [2:0] t);
    sv[0] = v[0]; sv[1] = v[1]; sv[2] = v[2];
    sl[0] = 4'(l0); sl[1] = 4'(l1); sl[2] = 4'(l2);
    st[0] = t[0]; st[1] = t[1]; st[2] = t[2];
    @(posedge clk); #1;
    sv[0] = 1'b0; sv[1] = 1'b0; sv[2] = 1'b0;
  endtask

  task automatic produce(input int k, input int n);
    logic hs;
    int   guard;
    for (int j = 0; j < n; j++) begin
      sv[k] = 1'b1; sl[k] = 4'(j); st[k] = (j == n - 1);
      guard = 0;
      do begin
        @(negedge clk); hs = rdy[k];
        @(posedge clk); #1;
        guard++;
      end while (!hs && guard < 200);
      if (!hs) chk($sformatf("E_prod%0d_timeout", k), 64'd0, 64'd1);
    end
    sv[k] = 1'b0;
  endtask

  initial begin
    int mbase, changes;
    logic [32:0] held_beat;
    logic seen;
    rst = 1'b1; mrdy = 1'b1;
    for (int i = 0; i < 3; i++) begin sv[i] = 1'b0; sl[i] = '0; st[i] = 1'b0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 64'(m.tvalid), 64'd0);
    chk("rst_tdata", 64'(m.tdata), 64'd0);
    chk("rst_tkeep", 64'(m.tkeep), 64'd0);
    chk("rst_tlast", 64'(m.tlast), 64'd0);
    chk("rst_mism", 64'(mism), 64'd0);
    chk("rst_stats", {stot, ssplit}, 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", 64'({rdy[2], rdy[1], rdy[0]}), 64'h7);

    // A: unanimous 5s, one-cycle latency
    drive(3'b111, 5, 5, 5, 3'b000);
    @(negedge clk); chk("A_lat", 64'(m.tvalid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("A_vld", 64'(m.tvalid), 64'd1);
    chk("A_keep", 64'(m.tkeep), 64'hF);
    idle(2);
    pop_chk("A_beat", eb(5, 3, 0));
    chk("A_count", 64'(q.size()), 64'd0);

    // B: skewed arrivals 3,7,3
    drive(3'b001, 3, 0, 0, 3'b000);
    idle(3);
    drive(3'b010, 0, 7, 0, 3'b000);
    idle(2);
    @(negedge clk);
    chk("B_held_ready", 64'({rdy[2], rdy[1], rdy[0]}), 64'h4);
    chk("B_no_out", 64'(m.tvalid), 64'd0);
    drive(3'b100, 0, 0, 3, 3'b000);
    @(negedge clk); chk("B_lat", 64'(m.tvalid), 64'd0);
    idle(3);
    pop_chk("B_beat", eb(3, 2, 0));

    // C: three-way split resolves to classifier 2
    drive(3'b111, 1, 2, 6, 3'b000);
    idle(3);
    pop_chk("C_beat", eb(6, 1, 0));
`ifdef ENSEMBLE_VOTE_STATS_EN
    chk("C_stat_total", 64'(stot), 64'd3);
    chk("C_stat_split", 64'(ssplit), 64'd1);
`else
    chk("C_stat_total", 64'(stot), 64'd0);
    chk("C_stat_split", 64'(ssplit), 64'd0);
`endif

    // D: tlast disagreement, then agreement
    mbase = mcnt;
    drive(3'b111, 4, 4, 4, 3'b011);
    idle(3);
    pop_chk("D_beat_mm", eb(4, 3, 0));
    chk("D_mism_once", 64'(mcnt - mbase), 64'd1);
    drive(3'b111, 4, 4, 4, 3'b111);
    idle(3);
    pop_chk("D_beat_last", eb(4, 3, 1));
    chk("D_mism_none", 64'(mcnt - mbase), 64'd1);

    // E: 20 cycles of back-pressure with all inputs streaming
    mrdy = 1'b0; changes = 0; seen = 1'b0; held_beat = '0;
    fork
      produce(0, 8);
      produce(1, 8);
      produce(2, 8);
      begin
        for (int c = 0; c < 20; c++) begin
          @(negedge clk);
          if (seen && (!m.tvalid || {m.tlast, m.tdata} != held_beat)) changes++;
          if (!seen && m.tvalid) begin seen = 1'b1; held_beat = {m.tlast, m.tdata}; end
          if (c == 15) chk("E_s_ready_low", 64'({rdy[2], rdy[1], rdy[0]}), 64'h0);
        end
        chk("E_stable", 64'(changes), 64'd0);
        chk("E_held_beat", 64'(held_beat), 64'(eb(0, 3, 0)));
        @(posedge clk); #1; mrdy = 1'b1;
      end
    join
    idle(4);
    chk("E_count", 64'(q.size()), 64'd8);
    for (int j = 0; j < 8; j++) pop_chk($sformatf("E_beat%0d", j), eb(j, 3, j == 7));
`ifdef ENSEMBLE_VOTE_STATS_EN
    chk("E_stat_total", 64'(stot), 64'd13);
`else
    chk("E_stat_total", 64'(stot), 64'd0);
`endif

    // F: reset with pending output and two full slots
    mrdy = 1'b0;
    drive(3'b111, 9, 9, 9, 3'b000);
    idle(2);
    drive(3'b011, 1, 1, 0, 3'b000);
    @(negedge clk);
    chk("F_pending", 64'(m.tvalid), 64'd1);
    chk("F_slot0_full", 64'(rdy[0]), 64'd0);
    #1 rst = 1'b1;
    #1 chk("F_rst_async", 64'(m.tvalid), 64'd0);
    chk("F_rst_keep", 64'(m.tkeep), 64'd0);
    @(posedge clk); #1; rst = 1'b0; mrdy = 1'b1;
    q.delete();
    drive(3'b111, 2, 2, 2, 3'b000);
    idle(3);
    chk("F_count", 64'(q.size()), 64'd1);
    pop_chk("F_beat", eb(2, 3, 0));
`ifdef ENSEMBLE_VOTE_STATS_EN
    chk("F_stat_total", 64'(stot), 64'd1);
`else
    chk("F_stat_total", 64'(stot), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL tb_timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
